// File: rtl/xor_serial_arbiter.sv
// Round-robin share of one 1-bit xor_gate among N_REQ requesters.
// Operands stream LSB-first; result returns with done and owner index.
module xor_gate (
  input  logic din_a,
  input  logic din_b,
  output logic dout
);
  assign dout = din_a ^ din_b;
endmodule

module xor_serial_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] op_a,
  input  logic [N_REQ*WIDTH-1:0] op_b,
  output logic [N_REQ-1:0]       gnt,
  output logic                   busy,
  output logic                   done,
  output logic [WIDTH-1:0]       result,
  output logic [$clog2(N_REQ)-1:0] done_id
);
  localparam int IDW = $clog2(N_REQ);
  localparam int SW  = IDW + 1;
  localparam int CW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [IDW-1:0]   done_id_q, done_id_d;
  logic [WIDTH-1:0] sh_a_q, sh_a_d;
  logic [WIDTH-1:0] sh_b_q, sh_b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IDW-1:0]   cur_id_q, cur_id_d;

  logic [WIDTH-1:0] a_arr [N_REQ];
  logic [WIDTH-1:0] b_arr [N_REQ];
  logic             win_vld;
  logic [IDW-1:0]   win_id;
  logic [IDW-1:0]   nxt_ptr;
  logic [SW-1:0]    s;
  logic             dout;

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign a_arr[g] = op_a[g*WIDTH +: WIDTH];
    assign b_arr[g] = op_b[g*WIDTH +: WIDTH];
  end

  xor_gate u_xor (
    .din_a (sh_a_q[0]),
    .din_b (sh_b_q[0]),
    .dout  (dout)
  );

  // scan req starting at rr_ptr, wrapping modulo N_REQ
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    s       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      s = {1'b0, rr_ptr_q} + SW'(i);
      if (s >= SW'(N_REQ)) s = s - SW'(N_REQ);
      if (!win_vld && req[s[IDW-1:0]]) begin
        win_vld = 1'b1;
        win_id  = s[IDW-1:0];
      end
    end
    nxt_ptr = (win_id == IDW'(N_REQ-1)) ? '0 : win_id + 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_d     = '0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    result_d  = result_q;
    done_id_d = done_id_q;
    sh_a_d    = sh_a_q;
    sh_b_d    = sh_b_q;
    res_d     = res_q;
    cnt_d     = cnt_q;
    cur_id_d  = cur_id_q;
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          gnt_d[win_id] = 1'b1;
          sh_a_d   = a_arr[win_id];
          sh_b_d   = b_arr[win_id];
          cur_id_d = win_id;
          rr_ptr_d = nxt_ptr;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        res_d = res_q >> 1;
        res_d[WIDTH-1] = dout;
        sh_a_d = sh_a_q >> 1;
        sh_b_d = sh_b_q >> 1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1)) begin
          result_d  = res_d;
          done_d    = 1'b1;
          done_id_d = cur_id_q;
          state_d   = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      done_id_q <= '0;
      sh_a_q    <= '0;
      sh_b_q    <= '0;
      res_q     <= '0;
      cnt_q     <= '0;
      cur_id_q  <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
      done_id_q <= done_id_d;
      sh_a_q    <= sh_a_d;
      sh_b_q    <= sh_b_d;
      res_q     <= res_d;
      cnt_q     <= cnt_d;
      cur_id_q  <= cur_id_d;
    end
  end

  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign result  = result_q;
  assign done_id = done_id_q;
endmodule

// File: tb/tb_xor_serial_arbiter.sv
// Directed bench for xor_serial_arbiter (N_REQ=4, WIDTH=8).
// Hand-computed grants, results and owner ids.
module tb_xor_serial_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [3:0]  gnt;
  logic        busy;
  logic        done;
  logic [7:0]  result;
  logic [1:0]  done_id;

  int total = 0;
  int bad = 0;

  xor_serial_arbiter #(.N_REQ(4), .WIDTH(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .op_a    (op_a),
    .op_b    (op_b),
    .gnt     (gnt),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .done_id (done_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_ops(input int i, input logic [7:0] a,
                         input logic [7:0] b);
    op_a[i*8 +: 8] = a;
    op_b[i*8 +: 8] = b;
  endtask

  task automatic wait_gnt();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gnt == 4'b0 && n < 40);
    chk("gnt_seen", {31'b0, gnt != 4'b0}, 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [3:0] eg,
                        input logic [7:0] er, input logic [1:0] eid,
                        input bit drop, input logic [3:0] setm);
    wait_gnt();
    chk({tag, "_gnt"}, gnt, eg);
    chk({tag, "_busy"}, busy, 1);
    if (drop) req = req & ~gnt;
    req = req | setm;
    repeat (7) @(negedge clk);
    chk({tag, "_early"}, {done, gnt}, 5'b0);
    @(negedge clk);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_res"}, result, er);
    chk({tag, "_id"}, done_id, eid);
    @(negedge clk);
    chk({tag, "_end"}, {done, busy}, 2'b0);
    chk({tag, "_hold"}, result, er);
  endtask

  task automatic mid_reset(input string tag);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk({tag, "_rst_gnt"}, gnt, 0);
    chk({tag, "_rst_flags"}, {busy, done}, 0);
    chk({tag, "_rst_res"}, result, 0);
    chk({tag, "_rst_id"}, done_id, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit seen_done;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mid_reset("t1");

    // single requester
    set_ops(0, 8'hA5, 8'h0F);
    req = 4'b0001;
    run_op("t2", 4'b0001, 8'hAA, 2'd0, 1, 4'b0);

    // all four at once from a fresh pointer
    mid_reset("t3");
    for (int i = 0; i < 4; i++) set_ops(i, 8'(8'h11 * (i + 1)), 8'hFF);
    req = 4'b1111;
    run_op("t3a", 4'b0001, 8'hEE, 2'd0, 1, 4'b0);
    run_op("t3b", 4'b0010, 8'hDD, 2'd1, 1, 4'b0);
    run_op("t3c", 4'b0100, 8'hCC, 2'd2, 1, 4'b0);
    run_op("t3d", 4'b1000, 8'hBB, 2'd3, 1, 4'b0);

    // fairness with 0 and 2 held, 1 joins mid-op
    set_ops(0, 8'h3C, 8'hC3);
    set_ops(1, 8'h80, 8'h01);
    set_ops(2, 8'h0F, 8'h01);
    req = 4'b0101;
    run_op("t4a", 4'b0001, 8'hFF, 2'd0, 0, 4'b0);
    run_op("t4b", 4'b0100, 8'h0E, 2'd2, 0, 4'b0);
    run_op("t4c", 4'b0001, 8'hFF, 2'd0, 0, 4'b0010);
    run_op("t4d", 4'b0010, 8'h81, 2'd1, 1, 4'b0);
    run_op("t4e", 4'b0100, 8'h0E, 2'd2, 0, 4'b0);
    run_op("t4f", 4'b0001, 8'hFF, 2'd0, 1, 4'b0);
    req = 4'b0000;
    @(negedge clk);

    // operand edge patterns
    set_ops(3, 8'hFF, 8'hFF);
    req = 4'b1000;
    run_op("t5a", 4'b1000, 8'h00, 2'd3, 1, 4'b0);
    set_ops(3, 8'h00, 8'hFF);
    req = 4'b1000;
    run_op("t5b", 4'b1000, 8'hFF, 2'd3, 1, 4'b0);
    set_ops(1, 8'h5A, 8'h5A);
    req = 4'b0010;
    run_op("t5c", 4'b0010, 8'h00, 2'd1, 1, 4'b0);

    // reset during the fourth shift cycle
    set_ops(0, 8'h12, 8'h34);
    req = 4'b0001;
    wait_gnt();
    chk("t6_gnt", gnt, 4'b0001);
    req = 4'b0000;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_done", done, 0);
    chk("t6_rst_res", result, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) seen_done = 1'b1;
    end
    chk("t6_no_done", seen_done, 0);
    req = 4'b0011;
    run_op("t6a", 4'b0001, 8'h26, 2'd0, 1, 4'b0);
    set_ops(2, 8'hF0, 8'h0F);
    req = 4'b0100;
    run_op("t6b", 4'b0100, 8'hFF, 2'd2, 1, 4'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
